sensor_scan_scheduler: RTL and testbench



---
 rtl/sensor_scan_scheduler.sv | 165 ++++++++++++++++
 tb/tb_sensor_scan_scheduler.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_scan_scheduler.sv
// Periodic four-sensor I2C scan: issues one read per sensor with retry/timeout,
// latches each 16-bit reading and emits a coherent feature vector with a one-cycle valid.
module sensor_scan_scheduler #(
    parameter int unsigned POLL_INTERVAL = 1000,
    parameter int unsigned TIMEOUT       = 4096,
    parameter int unsigned MAX_RETRY     = 2,
    parameter logic [6:0]  ADDR0         = 7'h44,
    parameter logic [6:0]  ADDR1         = 7'h5A,
    parameter logic [6:0]  ADDR2         = 7'h5C,
    parameter logic [6:0]  ADDR3         = 7'h23
) (
    input  logic        clk,
    input  logic        rst,
    output logic        cmd_valid,
    output logic [6:0]  cmd_addr,
    input  logic        cmd_ready,
    input  logic        rsp_valid,
    input  logic        rsp_nack,
    input  logic [15:0] rsp_data,
    output logic [63:0] features,
    output logic        feat_valid,
    output logic [3:0]  sensor_err,
    output logic        busy
);

    localparam int IVL_W = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
    localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IVL_W-1:0] IVL_LAST = IVL_W'(POLL_INTERVAL - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [2:0]       MAX_R    = 3'(MAX_RETRY);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, DONE} state_t;

    state_t           state_q, state_d;
    logic [IVL_W-1:0] ivl_q, ivl_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic [1:0]       idx_q, idx_d;
    logic [2:0]       retry_q, retry_d;
    logic [63:0]      feat_q, feat_d;
    logic [3:0]       err_q, err_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic [6:0]       cmd_addr_q, cmd_addr_d;
    logic             feat_valid_q, feat_valid_d;
    logic             busy_q, busy_d;
    logic             fail, adv;

    function automatic logic [6:0] addr_of(input logic [1:0] i);
        case (i)
            2'd0:    addr_of = ADDR0;
            2'd1:    addr_of = ADDR1;
            2'd2:    addr_of = ADDR2;
            default: addr_of = ADDR3;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        ivl_d   = ivl_q;
        to_d    = to_q;
        idx_d   = idx_q;
        retry_d = retry_q;
        feat_d  = feat_q;
        err_d   = err_q;
        fail    = 1'b0;
        adv     = 1'b0;
        case (state_q)
            IDLE: begin
                if (ivl_q == IVL_LAST) begin
                    state_d = ISSUE;
                    ivl_d   = '0;
                    idx_d   = 2'd0;
                    retry_d = 3'd0;
                end else begin
                    ivl_d = ivl_q + IVL_W'(1);
                end
            end
            ISSUE: begin
                if (cmd_valid_q && cmd_ready) begin
                    state_d = WAIT_RSP;
                    to_d    = '0;
                end
            end
            WAIT_RSP: begin
                to_d = to_q + TO_W'(1);
                // A response arriving on the timeout cycle still takes precedence.
                if (rsp_valid) begin
                    if (!rsp_nack) begin
                        feat_d[{idx_q, 4'b0000} +: 16] = rsp_data;
                        err_d[idx_q] = 1'b0;
                        adv = 1'b1;
                    end else begin
                        fail = 1'b1;
                    end
                end else if (to_q == TO_LAST) begin
                    fail = 1'b1;
                end
                if (fail) begin
                    if (retry_q < MAX_R) begin
                        retry_d = retry_q + 3'd1;
                        state_d = ISSUE;
                    end else begin
                        err_d[idx_q] = 1'b1;
                        adv = 1'b1;
                    end
                end
                if (adv) begin
                    if (idx_q == 2'd3) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        retry_d = 3'd0;
                        state_d = ISSUE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                ivl_d   = '0;
                idx_d   = 2'd0;
            end
            default: state_d = IDLE;
        endcase
        // Outputs are derived from the next state so they are registered, not decoded.
        cmd_valid_d  = (state_d == ISSUE);
        cmd_addr_d   = addr_of(idx_d);
        feat_valid_d = (state_d == DONE);
        busy_d       = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ivl_q        <= '0;
            to_q         <= '0;
            idx_q        <= 2'd0;
            retry_q      <= 3'd0;
            feat_q       <= '0;
            err_q        <= '0;
            cmd_valid_q  <= 1'b0;
            cmd_addr_q   <= ADDR0;
            feat_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ivl_q        <= ivl_d;
            to_q         <= to_d;
            idx_q        <= idx_d;
            retry_q      <= retry_d;
            feat_q       <= feat_d;
            err_q        <= err_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_addr_q   <= cmd_addr_d;
            feat_valid_q <= feat_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign cmd_valid  = cmd_valid_q;
    assign cmd_addr   = cmd_addr_q;
    assign features   = feat_q;
    assign feat_valid = feat_valid_q;
    assign sensor_err = err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_sensor_scan_scheduler.sv
// Directed bench for sensor_scan_scheduler: nominal scan, retry, persistent NACK,
// timeout window, stray response, command backpressure and reset mid-scan.
module tb_sensor_scan_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic [6:0]  cmd_addr;
    logic        cmd_ready;
    logic        rsp_valid;
    logic        rsp_nack;
    logic [15:0] rsp_data;
    logic [63:0] features;
    logic        feat_valid;
    logic [3:0]  sensor_err;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    int cnt;

    sensor_scan_scheduler #(
        .POLL_INTERVAL(16),
        .TIMEOUT      (32),
        .MAX_RETRY    (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_addr  (cmd_addr),
        .cmd_ready (cmd_ready),
        .rsp_valid (rsp_valid),
        .rsp_nack  (rsp_nack),
        .rsp_data  (rsp_data),
        .features  (features),
        .feat_valid(feat_valid),
        .sensor_err(sensor_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_cmd(input logic [6:0] ea);
        int n = 0;
        while (!cmd_valid && n < 300) begin
            tick;
            n++;
        end
        chk("cmd_wait", {63'd0, cmd_valid}, 64'd1);
        chk("cmd_addr", {57'd0, cmd_addr}, {57'd0, ea});
    endtask

    task automatic handshake(input int rdy_dly, input logic [6:0] ea);
        for (int i = 0; i < rdy_dly; i++) begin
            tick;
            chk("bp_valid_hold", {63'd0, cmd_valid}, 64'd1);
            chk("bp_addr_hold", {57'd0, cmd_addr}, {57'd0, ea});
        end
        cmd_ready = 1'b1;
        tick;
        cmd_ready = 1'b0;
        chk("cmd_drop", {63'd0, cmd_valid}, 64'd0);
        chk("busy_wait", {63'd0, busy}, 64'd1);
    endtask

    // One full command/response exchange with a response 5 cycles after accept.
    task automatic serve(input logic [6:0] ea, input logic [1:0] idx, input logic nack,
                         input logic [15:0] data, input int rdy_dly,
                         input logic [15:0] exp_slot, input logic exp_next);
        wait_cmd(ea);
        handshake(rdy_dly, ea);
        repeat (4) tick;
        rsp_valid = 1'b1;
        rsp_nack  = nack;
        rsp_data  = data;
        tick;
        rsp_valid = 1'b0;
        rsp_nack  = 1'b0;
        chk("slot_update", {48'd0, features[idx*16 +: 16]}, {48'd0, exp_slot});
        chk("next_cmd_gap", {63'd0, cmd_valid}, {63'd0, exp_next});
    endtask

    task automatic wait_done;
        int n = 0;
        while (!feat_valid && n < 300) begin
            tick;
            n++;
        end
        chk("feat_valid_seen", {63'd0, feat_valid}, 64'd1);
    endtask

    initial begin
        rst = 1'b1; cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_nack = 1'b0; rsp_data = '0;
        repeat (3) tick;
        chk("rst_cmd_valid", {63'd0, cmd_valid}, 64'd0);
        chk("rst_cmd_addr", {57'd0, cmd_addr}, 64'h44);
        chk("rst_features", features, 64'd0);
        chk("rst_feat_valid", {63'd0, feat_valid}, 64'd0);
        chk("rst_sensor_err", {60'd0, sensor_err}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);

        // First command appears after POLL_INTERVAL edges with rst low
        rst = 1'b0;
        cnt = 0;
        while (!cmd_valid && cnt < 100) begin
            tick;
            cnt++;
        end
        chk("first_cmd_latency", 64'(cnt), 64'd16);

        // Scan 1: nominal
        serve(7'h44, 2'd0, 1'b0, 16'h1234, 0, 16'h1234, 1'b1);
        serve(7'h5A, 2'd1, 1'b0, 16'h0456, 0, 16'h0456, 1'b1);
        serve(7'h5C, 2'd2, 1'b0, 16'h7A10, 0, 16'h7A10, 1'b1);
        serve(7'h23, 2'd3, 1'b0, 16'h00C8, 0, 16'h00C8, 1'b0);
        chk("s1_feat_valid", {63'd0, feat_valid}, 64'd1);
        chk("s1_features", features, 64'h00C8_7A10_0456_1234);
        chk("s1_err", {60'd0, sensor_err}, 64'd0);
        tick;
        cnt = 1;
        chk("s1_feat_pulse", {63'd0, feat_valid}, 64'd0);
        chk("s1_idle_busy", {63'd0, busy}, 64'd0);
        while (!cmd_valid && cnt < 100) begin
            tick;
            cnt++;
        end
        chk("s1_rescan_gap", 64'(cnt), 64'd17);

        // Scan 2: single NACK on the air-quality sensor
        serve(7'h44, 2'd0, 1'b0, 16'h1111, 0, 16'h1111, 1'b1);
        serve(7'h5A, 2'd1, 1'b1, 16'hFFFF, 0, 16'h0456, 1'b1);
        chk("s2_retry_addr", {57'd0, cmd_addr}, 64'h5A);
        chk("s2_err_after_nack", {60'd0, sensor_err}, 64'd0);
        serve(7'h5A, 2'd1, 1'b0, 16'h0099, 0, 16'h0099, 1'b1);
        serve(7'h5C, 2'd2, 1'b0, 16'h7A10, 0, 16'h7A10, 1'b1);
        serve(7'h23, 2'd3, 1'b0, 16'h00C8, 0, 16'h00C8, 1'b0);
        chk("s2_feat_valid", {63'd0, feat_valid}, 64'd1);
        chk("s2_features", features, 64'h00C8_7A10_0099_1111);
        chk("s2_err", {60'd0, sensor_err}, 64'd0);

        // Scan 3: pressure sensor NACKs all three attempts
        serve(7'h44, 2'd0, 1'b0, 16'h2222, 0, 16'h2222, 1'b1);
        serve(7'h5A, 2'd1, 1'b0, 16'h3333, 0, 16'h3333, 1'b1);
        serve(7'h5C, 2'd2, 1'b1, 16'hAAAA, 0, 16'h7A10, 1'b1);
        chk("s3_retry1_addr", {57'd0, cmd_addr}, 64'h5C);
        serve(7'h5C, 2'd2, 1'b1, 16'hBBBB, 0, 16'h7A10, 1'b1);
        chk("s3_retry2_addr", {57'd0, cmd_addr}, 64'h5C);
        chk("s3_err_mid", {60'd0, sensor_err}, 64'd0);
        serve(7'h5C, 2'd2, 1'b1, 16'hCCCC, 0, 16'h7A10, 1'b1);
        chk("s3_err_set", {60'd0, sensor_err}, 64'h4);
        chk("s3_advance_addr", {57'd0, cmd_addr}, 64'h23);
        serve(7'h23, 2'd3, 1'b0, 16'h4444, 0, 16'h4444, 1'b0);
        chk("s3_feat_valid", {63'd0, feat_valid}, 64'd1);
        chk("s3_features", features, 64'h4444_7A10_3333_2222);
        chk("s3_err", {60'd0, sensor_err}, 64'h4);

        // Scan 4: light sensor never answers; each attempt times out after 32 cycles
        serve(7'h44, 2'd0, 1'b0, 16'h6666, 0, 16'h6666, 1'b1);
        serve(7'h5A, 2'd1, 1'b0, 16'h7777, 0, 16'h7777, 1'b1);
        serve(7'h5C, 2'd2, 1'b0, 16'h5555, 0, 16'h5555, 1'b1);
        chk("s4_err_clear", {60'd0, sensor_err}, 64'd0);
        for (int a = 0; a < 3; a++) begin
            wait_cmd(7'h23);
            handshake(0, 7'h23);
            cnt = 0;
            while (!cmd_valid && !feat_valid && cnt < 100) begin
                tick;
                cnt++;
            end
            chk("s4_timeout_window", 64'(cnt), 64'd32);
        end
        chk("s4_feat_valid", {63'd0, feat_valid}, 64'd1);
        chk("s4_err", {60'd0, sensor_err}, 64'h8);
        chk("s4_features", features, 64'h4444_5555_7777_6666);

        // Stray response during IDLE is ignored
        tick;
        tick;
        rsp_valid = 1'b1;
        rsp_data  = 16'hDEAD;
        tick;
        rsp_valid = 1'b0;
        tick;
        chk("stray_features", features, 64'h4444_5555_7777_6666);
        chk("stray_err", {60'd0, sensor_err}, 64'h8);
        chk("stray_busy", {63'd0, busy}, 64'd0);
        chk("stray_cmd_valid", {63'd0, cmd_valid}, 64'd0);

        // Scan 5: backpressure on the first command, then reset while waiting on 0x5C
        serve(7'h44, 2'd0, 1'b0, 16'h0101, 10, 16'h0101, 1'b1);
        serve(7'h5A, 2'd1, 1'b0, 16'h0202, 0, 16'h0202, 1'b1);
        wait_cmd(7'h5C);
        handshake(0, 7'h5C);
        tick;
        tick;
        rst = 1'b1;
        tick;
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_cmd_valid", {63'd0, cmd_valid}, 64'd0);
        chk("mid_rst_features", features, 64'd0);
        chk("mid_rst_err", {60'd0, sensor_err}, 64'd0);
        rst = 1'b0;
        rsp_valid = 1'b1;
        rsp_data  = 16'hBEEF;
        tick;
        rsp_valid = 1'b0;
        cnt = 1;
        chk("late_rsp_features", features, 64'd0);
        chk("late_rsp_busy", {63'd0, busy}, 64'd0);
        while (!cmd_valid && cnt < 100) begin
            tick;
            cnt++;
        end
        chk("post_rst_latency", 64'(cnt), 64'd16);
        chk("post_rst_addr", {57'd0, cmd_addr}, 64'h44);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
